// File: rtl/disp_mux_if.sv
// Bundle of display-multiplexer data, control and drive signals shared between
// the nibble source (master) and the scheduler (slave).
interface disp_mux_if #(
    parameter int NDIG = 2
);
    logic [4*NDIG-1:0] digits_in;
    logic              load;
    logic [NDIG-1:0]   dig_en;
    logic [3:0]        nibble;
    logic [NDIG-1:0]   an_n;
    logic              frame_start;
    logic              pending;

    modport master (
        output digits_in, load, dig_en,
        input  nibble, an_n, frame_start, pending
    );

    modport slave (
        input  digits_in, load, dig_en,
        output nibble, an_n, frame_start, pending
    );
endinterface

// File: rtl/disp_mux_ctrl.sv
// Seven-segment time-multiplex scheduler: blank/on slot sequencing per digit,
// with double-buffered digit values committed only at frame boundaries.
module disp_mux_ctrl #(
    parameter int NDIG         = 2,
    parameter int ON_CYCLES    = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    disp_mux_if.slave  bus
);
    localparam int MAXC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(NDIG);
    localparam int DW   = 4 * NDIG;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
    localparam logic [IW-1:0] IDX_ONE    = IW'(1);

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } phase_t;

    phase_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [IW-1:0]   idx_r;
    logic [DW-1:0]   active_r;
    logic [DW-1:0]   pend_buf_r;
    logic            pending_r;
    logic [NDIG-1:0] an_n_r;
    logic [3:0]      nibble_r;
    logic            frame_start_r;

    logic            blank_done_s;
    logic            on_done_s;
    logic            commit_s;
    logic            on_next_s;
    logic [IW-1:0]   idx_next_s;
    logic [DW-1:0]   active_next_s;
    logic [NDIG-1:0] an_next_s;
    logic [3:0]      nibble_next_s;

    // Next-slot decode: phase ends, commit edge, and the values the registered outputs take next.
    always_comb begin
        blank_done_s  = (state_r == BLANK) && (cnt_r == BLANK_LAST);
        on_done_s     = (state_r == ON) && (cnt_r == ON_LAST);
        commit_s      = on_done_s && (idx_r == IDX_LAST);
        on_next_s     = (state_r == ON) ? !on_done_s : blank_done_s;
        an_next_s     = '1;
        nibble_next_s = 4'h0;

        if (on_done_s) begin
            idx_next_s = (idx_r == IDX_LAST) ? '0 : (idx_r + IDX_ONE);
        end else begin
            idx_next_s = idx_r;
        end

        // A load on the commit edge bypasses the pending buffer entirely.
        if (commit_s && bus.load) begin
            active_next_s = bus.digits_in;
        end else if (commit_s && pending_r) begin
            active_next_s = pend_buf_r;
        end else begin
            active_next_s = active_r;
        end

        for (int i = 0; i < NDIG; i++) begin
            if (idx_next_s == IW'(i)) begin
                nibble_next_s = active_next_s[4*i +: 4];
                an_next_s[i]  = !(on_next_s && bus.dig_en[i]);
            end else begin
                an_next_s[i]  = 1'b1;
            end
        end
    end

    // Phase FSM, slot index, digit buffers and registered display outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= BLANK;
            cnt_r         <= '0;
            idx_r         <= '0;
            active_r      <= '0;
            pend_buf_r    <= '0;
            pending_r     <= 1'b0;
            an_n_r        <= '1;
            nibble_r      <= 4'h0;
            frame_start_r <= 1'b0;
        end else begin
            case (state_r)
                BLANK: begin
                    if (blank_done_s) begin
                        state_r <= ON;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                ON: begin
                    if (on_done_s) begin
                        state_r <= BLANK;
                        cnt_r   <= '0;
                        idx_r   <= idx_next_s;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= BLANK;
                    cnt_r   <= '0;
                end
            endcase

            if (commit_s) begin
                active_r   <= active_next_s;
                pending_r  <= 1'b0;
            end else if (bus.load) begin
                pend_buf_r <= bus.digits_in;
                pending_r  <= 1'b1;
            end else begin
                pending_r  <= pending_r;
            end

            if (on_done_s) begin
                nibble_r <= nibble_next_s;
            end else begin
                nibble_r <= nibble_r;
            end

            an_n_r        <= an_next_s;
            frame_start_r <= commit_s;
        end
    end

    assign bus.an_n        = an_n_r;
    assign bus.nibble      = nibble_r;
    assign bus.pending     = pending_r;
    assign bus.frame_start = frame_start_r;
endmodule

// File: tb/tb_disp_mux_ctrl.sv
// Self-checking bench for disp_mux_ctrl: directed vector table, randomized run
// against a frame-arithmetic reference model, and multi-cycle corner sequences.
module tb_disp_mux_ctrl;
    localparam int NDIG  = 2;
    localparam int ONC   = 4;
    localparam int BLC   = 2;
    localparam int SLOT  = ONC + BLC;
    localparam int FRAME = NDIG * SLOT;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    disp_mux_if #(.NDIG(NDIG)) bus ();

    disp_mux_ctrl #(.NDIG(NDIG), .ON_CYCLES(ONC), .BLANK_CYCLES(BLC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: edges since reset release and the frame-level buffers.
    int          cyc;
    logic [7:0]  m_shown;
    logic [7:0]  m_pbuf;
    logic        m_pend;
    logic [1:0]  m_den;

    typedef struct packed {
        logic       ld;
        logic [7:0] din;
        logic [1:0] an;
        logic [3:0] nib;
        logic       pd;
        logic       fs;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic ld, logic [7:0] din, logic [1:0] an,
                                logic [3:0] nib, logic pd, logic fs);
        vec_t v;
        v = '{ld, din, an, nib, pd, fs};
        return v;
    endfunction

    function automatic logic [7:0] actual();
        return {bus.an_n, bus.nibble, bus.pending, bus.frame_start};
    endfunction

    function automatic logic [7:0] model_exp();
        int         pos, slot;
        logic [1:0] an;
        pos  = cyc % FRAME;
        slot = pos / SLOT;
        an   = 2'b11;
        if ((pos % SLOT) >= BLC && m_den[slot]) an[slot] = 1'b0;
        return {an, m_shown[slot*4 +: 4], m_pend, (cyc > 0 && pos == 0)};
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual{an_n,nib,pend,fs}=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        cyc = 0; m_shown = 8'h00; m_pbuf = 8'h00; m_pend = 1'b0; m_den = bus.dig_en;
    endtask

    // One clock edge: the model consumes the inputs the DUT sees on that edge.
    task automatic advance();
        @(posedge clk);
        if ((cyc + 1) % FRAME == 0) begin
            if (bus.load) m_shown = bus.digits_in;
            else if (m_pend) m_shown = m_pbuf;
            m_pend = 1'b0;
        end else if (bus.load) begin
            m_pbuf = bus.digits_in;
            m_pend = 1'b1;
        end
        m_den = bus.dig_en;
        cyc++;
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        chk("model", actual(), model_exp());
    endtask

    task automatic wait_pos(int p);
        int n = 0;
        do begin
            advance(); sample(); n++;
        end while ((cyc % FRAME) != p && n < 2 * FRAME);
        checks++;
        if ((cyc % FRAME) != p) begin
            failures++;
            $display("FAIL wait_pos actual=%0d required=%0d", cyc % FRAME, p);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int lo0, lo1;
        bus.digits_in = 8'h00;
        bus.load      = 1'b0;
        bus.dig_en    = 2'b11;

        // Directed table: schedule after reset, then a 5A load mid-frame.
        for (int c = 0; c < 26; c++) begin
            logic [1:0] an;
            logic [3:0] nib;
            int p;
            p   = c % FRAME;
            an  = (p >= 2 && p <= 5) ? 2'b10 : ((p >= 8) ? 2'b01 : 2'b11);
            nib = (c < 12) ? 4'h0 : ((p < 6) ? 4'hA : 4'h5);
            tbl.push_back(mk(c == 3, (c == 3) ? 8'h5A : 8'h00, an, nib,
                             (c >= 4 && c <= 11), (c == 12 || c == 24)));
        end

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            if (i > 0) advance();
            bus.load      = tbl[i].ld;
            bus.digits_in = tbl[i].din;
            sample();
            chk("table", actual(), {tbl[i].an, tbl[i].nib, tbl[i].pd, tbl[i].fs});
        end

        // Randomized loads and digit enables against the model.
        for (int i = 0; i < 600; i++) begin
            advance();
            bus.load      = ($urandom_range(0, 3) == 0);
            bus.digits_in = 8'($urandom);
            if ($urandom_range(0, 7) == 0) bus.dig_en = 2'($urandom);
            sample();
        end
        bus.load   = 1'b0;
        bus.dig_en = 2'b01;

        // Digit 1 disabled: only digit 0 lights, 4 cycles per frame.
        wait_pos(0);
        lo0 = 0; lo1 = 0;
        for (int i = 0; i < FRAME; i++) begin
            advance(); sample();
            if (!bus.an_n[0]) lo0++;
            if (!bus.an_n[1]) lo1++;
        end
        chk("dig_en_lo_counts", {4'(lo0), 4'(lo1)}, {4'd4, 4'd0});
        chk("dig_en_frame_start", {7'd0, bus.frame_start}, 8'h01);
        bus.dig_en = 2'b11;

        // Reset asserted mid-ON with an update pending.
        wait_pos(1);
        bus.load = 1'b1; bus.digits_in = 8'hE3;
        advance(); bus.load = 1'b0; sample();
        wait_pos(3);
        #2 reset = 1'b0;
        #1 chk("async_reset", actual(), {2'b11, 4'h0, 1'b0, 1'b0});
        do_reset();
        sample();
        chk("post_reset", actual(), {2'b11, 4'h0, 1'b0, 1'b0});

        // Pending 77 discarded by a 9C load on the commit edge.
        wait_pos(4);
        bus.load = 1'b1; bus.digits_in = 8'h77;
        advance(); bus.load = 1'b0; sample();
        chk("pend_77", {7'd0, bus.pending}, 8'h01);
        wait_pos(11);
        bus.load = 1'b1; bus.digits_in = 8'h9C;
        advance(); bus.load = 1'b0; sample();
        chk("commit_bypass", actual(), {2'b11, 4'hC, 1'b0, 1'b1});
        wait_pos(3);
        chk("show_C", actual(), {2'b10, 4'hC, 1'b0, 1'b0});
        wait_pos(8);
        chk("show_9", actual(), {2'b01, 4'h9, 1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
